// File: rtl/tt_mux_seq.sv
// Sequenced project mux: break-before-make switching between NUM_PROJ project wrappers.
// Optional MUX_OW_REG_EN registers the routed output word (one extra cycle of latency).

module tt_mux_seq_slot #(
    parameter int IW_W = 18,
    parameter int OW_W = 24
) (
    input  logic            ena_i,
    input  logic            route_i,
    input  logic [IW_W-1:0] iw_i,
    input  logic [OW_W-1:0] ow_i,
    output logic [IW_W-1:0] iw_o,
    output logic [OW_W-1:0] ow_o
);
    assign iw_o = ena_i   ? iw_i : '0;
    assign ow_o = route_i ? ow_i : '0;
endmodule

module tt_mux_seq #(
    parameter int NUM_PROJ      = 8,
    parameter int ADDR_W        = 5,
    parameter int IW_W          = 18,
    parameter int OW_W          = 24,
    parameter int GUARD_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ena_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [IW_W-1:0]          iw_i,
    input  logic [NUM_PROJ*OW_W-1:0] proj_ow_i,
    output logic [NUM_PROJ-1:0]      proj_ena_o,
    output logic [NUM_PROJ*IW_W-1:0] proj_iw_o,
    output logic [OW_W-1:0]          ow_o,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int CNT_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_ACTIVE, S_OFF} state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] idx;
    } req_t;

    req_t               req_q;
    logic               err_q;
    state_t             state_q;
    logic [ADDR_W-1:0]  cur_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_PROJ-1:0] proj_ena_q;

    logic addr_ok;
    logic req_hit;

    assign addr_ok = ({1'b0, addr_i} < (ADDR_W+1)'(NUM_PROJ));
    assign req_hit = req_q.vld && (req_q.idx == cur_q);

    function automatic logic [NUM_PROJ-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NUM_PROJ-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            oh[k] = (idx == ADDR_W'(k));
        end
        return oh;
    endfunction

    // Out-of-range requests collapse to "none" so the FSM only ever sees legal slots.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            req_q.vld <= ena_i && addr_ok;
            req_q.idx <= (ena_i && addr_ok) ? addr_i : '0;
            err_q     <= ena_i && !addr_ok;
        end
    end

    // Enables are loaded alongside the state transition so they track the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            proj_ena_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_q.vld) begin
                        cur_q      <= req_q.idx;
                        cnt_q      <= SETTLE_C;
                        state_q    <= S_ON;
                        proj_ena_q <= onehot(req_q.idx);
                    end
                end
                S_ON: begin
                    if (!req_hit) begin
                        cnt_q      <= GUARD_C;
                        state_q    <= S_OFF;
                        proj_ena_q <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= S_ACTIVE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (!req_hit) begin
                        cnt_q      <= GUARD_C;
                        state_q    <= S_OFF;
                        proj_ena_q <= '0;
                    end
                end
                S_OFF: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (req_q.vld) begin
                        cur_q      <= req_q.idx;
                        cnt_q      <= SETTLE_C;
                        state_q    <= S_ON;
                        proj_ena_q <= onehot(req_q.idx);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    proj_ena_q <= '0;
                end
            endcase
        end
    end

    logic [NUM_PROJ-1:0]           route;
    logic [NUM_PROJ-1:0][OW_W-1:0] proj_ow_a;
    logic [NUM_PROJ-1:0][OW_W-1:0] slot_ow;
    logic [NUM_PROJ-1:0][IW_W-1:0] slot_iw;
    logic [OW_W-1:0]               ow_mux;

    assign proj_ow_a = proj_ow_i;
    assign route     = (state_q == S_ACTIVE) ? proj_ena_q : '0;

    for (genvar k = 0; k < NUM_PROJ; k++) begin : g_slot
        tt_mux_seq_slot #(
            .IW_W (IW_W),
            .OW_W (OW_W)
        ) u_slot (
            .ena_i   (proj_ena_q[k]),
            .route_i (route[k]),
            .iw_i    (iw_i),
            .ow_i    (proj_ow_a[k]),
            .iw_o    (slot_iw[k]),
            .ow_o    (slot_ow[k])
        );
    end

    // At most one route bit is set, so an OR across slots is the mux.
    always_comb begin
        ow_mux = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            ow_mux = ow_mux | slot_ow[k];
        end
    end

`ifdef MUX_OW_REG_EN
    logic [OW_W-1:0] ow_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ow_q <= '0;
        end else begin
            ow_q <= ow_mux;
        end
    end

    assign ow_o = ow_q;
`else
    assign ow_o = ow_mux;
`endif

    assign proj_ena_o = proj_ena_q;
    assign proj_iw_o  = slot_iw;
    assign busy_o     = (state_q == S_ON) || (state_q == S_OFF);
    assign err_o      = err_q;

endmodule

// File: tb/tb_tt_mux_seq.sv
// Directed bench for tt_mux_seq: switching sequence, abort, range errors, enable drop and reset.
`timescale 1ns/1ps

module tb_tt_mux_seq;
    localparam int NUM_PROJ = 8;
    localparam int ADDR_W   = 5;
    localparam int IW_W     = 18;
    localparam int OW_W     = 24;
`ifdef MUX_OW_REG_EN
    localparam bit OW_REG = 1'b1;
`else
    localparam bit OW_REG = 1'b0;
`endif

    typedef logic [143:0] val_t;

    logic                     clk_i;
    logic                     rst_i;
    logic                     ena_i;
    logic [ADDR_W-1:0]        addr_i;
    logic [IW_W-1:0]          iw_i;
    logic [NUM_PROJ*OW_W-1:0] proj_ow_i;
    logic [NUM_PROJ-1:0]      proj_ena_o;
    logic [NUM_PROJ*IW_W-1:0] proj_iw_o;
    logic [OW_W-1:0]          ow_o;
    logic                     busy_o;
    logic                     err_o;

    int checks = 0;
    int errors = 0;

    tt_mux_seq dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ena_i      (ena_i),
        .addr_i     (addr_i),
        .iw_i       (iw_i),
        .proj_ow_i  (proj_ow_i),
        .proj_ena_o (proj_ena_o),
        .proj_iw_o  (proj_iw_o),
        .ow_o       (ow_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input val_t act, input val_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [OW_W-1:0] pow(input int s);
        return {8'hC0 + 8'(s), 16'h5A00 + 16'(s)};
    endfunction

    function automatic val_t iw_exp(input int s);
        val_t e;
        e = '0;
        e[s*IW_W +: IW_W] = iw_i;
        return e;
    endfunction

    function automatic val_t oh(input int s);
        val_t e;
        e = '0;
        e[s] = 1'b1;
        return e;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic off_phase(input logic [OW_W-1:0] first_ow);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("off_ena",  val_t'(proj_ena_o), '0);
            chk("off_busy", val_t'(busy_o), 1);
            chk("off_iw",   val_t'(proj_iw_o), '0);
            chk("off_ow",   val_t'(ow_o), (i == 0) ? val_t'(first_ow) : '0);
        end
    endtask

    task automatic on_phase(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("on_ena",  val_t'(proj_ena_o), oh(s));
            chk("on_busy", val_t'(busy_o), 1);
            chk("on_iw",   val_t'(proj_iw_o), iw_exp(s));
            chk("on_ow",   val_t'(ow_o), '0);
        end
    endtask

    task automatic to_active(input int s);
        step();
        if (OW_REG) begin
            chk("act_ow_lat", val_t'(ow_o), '0);
            step();
        end
        chk("act_ena",  val_t'(proj_ena_o), oh(s));
        chk("act_busy", val_t'(busy_o), 0);
        chk("act_ow",   val_t'(ow_o), val_t'(pow(s)));
    endtask

    function automatic logic [OW_W-1:0] prev_ow(input int s);
        return OW_REG ? pow(s) : '0;
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i) chk("onehot", val_t'($onehot0(proj_ena_o)), 1);
    end

    initial begin
        rst_i  = 1'b1;
        ena_i  = 1'b0;
        addr_i = '0;
        iw_i   = 18'h3FFFF;
        for (int k = 0; k < NUM_PROJ; k++) proj_ow_i[k*OW_W +: OW_W] = pow(k);

        #12;
        chk("rst_ena",  val_t'(proj_ena_o), '0);
        chk("rst_iw",   val_t'(proj_iw_o), '0);
        chk("rst_ow",   val_t'(ow_o), '0);
        chk("rst_busy", val_t'(busy_o), 0);
        chk("rst_err",  val_t'(err_o), 0);
        rst_i  = 1'b0;
        ena_i  = 1'b1;
        addr_i = 5'd3;

        // edge 1: request latched only
        step();
        chk("e1_ena",  val_t'(proj_ena_o), '0);
        chk("e1_busy", val_t'(busy_o), 0);
        on_phase(3, 4);
        to_active(3);

        // 3 -> 5 full switch
        addr_i = 5'd5;
        step();
        chk("sw_hold_ena", val_t'(proj_ena_o), oh(3));
        chk("sw_hold_ow",  val_t'(ow_o), val_t'(pow(3)));
        off_phase(prev_ow(3));
        on_phase(5, 4);
        to_active(5);

        // back to 3, then 3 -> 5 aborted mid-settle back to 3
        addr_i = 5'd3;
        step();
        off_phase(prev_ow(5));
        on_phase(3, 4);
        to_active(3);
        addr_i = 5'd5;
        step();
        off_phase(prev_ow(3));
        on_phase(5, 2);
        addr_i = 5'd3;
        on_phase(5, 1);
        off_phase('0);
        on_phase(3, 4);
        to_active(3);

        // out-of-range request drains to IDLE
        addr_i = 5'd9;
        step();
        chk("err_set",      val_t'(err_o), 1);
        chk("err_hold_ena", val_t'(proj_ena_o), oh(3));
        off_phase(prev_ow(3));
        step();
        chk("err_idle_ena",  val_t'(proj_ena_o), '0);
        chk("err_idle_busy", val_t'(busy_o), 0);
        chk("err_idle_ow",   val_t'(ow_o), '0);
        chk("err_idle_err",  val_t'(err_o), 1);
        addr_i = 5'd2;
        step();
        chk("err_clr",     val_t'(err_o), 0);
        chk("err_clr_ena", val_t'(proj_ena_o), '0);
        on_phase(2, 4);
        to_active(2);

        // top legal slot, then first illegal index
        addr_i = 5'd7;
        step();
        chk("top_err", val_t'(err_o), 0);
        off_phase(prev_ow(2));
        on_phase(7, 4);
        to_active(7);
        addr_i = 5'd8;
        step();
        chk("bound_err", val_t'(err_o), 1);
        off_phase(prev_ow(7));
        step();
        chk("bound_idle_ena", val_t'(proj_ena_o), '0);

        // gated input word on slot 1, then drop ena
        addr_i = 5'd1;
        step();
        on_phase(1, 4);
        to_active(1);
        iw_i = 18'h2A5A5;
        #1;
        chk("iw_slot1", val_t'(proj_iw_o), val_t'(18'h2A5A5) << IW_W);
        ena_i = 1'b0;
        step();
        chk("drop_hold_ena", val_t'(proj_ena_o), oh(1));
        off_phase(prev_ow(1));
        step();
        chk("drop_idle_ena",  val_t'(proj_ena_o), '0);
        chk("drop_idle_iw",   val_t'(proj_iw_o), '0);
        chk("drop_idle_ow",   val_t'(ow_o), '0);
        chk("drop_idle_busy", val_t'(busy_o), 0);

        // asynchronous reset in the middle of ON
        ena_i  = 1'b1;
        addr_i = 5'd4;
        step();
        on_phase(4, 2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_ena",  val_t'(proj_ena_o), '0);
        chk("arst_iw",   val_t'(proj_iw_o), '0);
        chk("arst_busy", val_t'(busy_o), 0);
        #2;
        rst_i = 1'b0;
        step();
        chk("arst_post_ena", val_t'(proj_ena_o), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
